interrupt_control_block: RTL and testbench
==========================================

# interrupt_control_block

Interrupt controller feeding the processor's single `interrupt` input. It latches rising edges on four external request lines, applies a per-line enable mask, and picks the highest-priority enabled request. It then holds `interrupt` high with a jump vector until the core acknowledges, and tracks the in-service period until end-of-interrupt. It sits directly upstream of the jump-control stage and is clocked on the processor clock.

## Interface
Parameters:
- `VECTOR_BASE`, default 16'h00F0: program-memory address of the IRQ0 handler.
- `VECTOR_STRIDE`, default 16'd4: address spacing between consecutive handlers.

Ports:
- `clk`, input, 1: processor clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `irq_req`, input, 4: external request lines; a rising edge requests service.
- `mask_we`, input, 1: when high, load `mask_in` into the enable register.
- `mask_in`, input, 4: new enable mask (1 = line enabled).
- `irq_ack`, input, 1: core has taken the jump; valid only in REQ.
- `eoi`, input, 1: handler finished; valid only in SERVICE.
- `interrupt`, output, 1: request to jump control; registered.
- `irq_vector`, output, 16: handler address for the current request; registered.
- `irq_id`, output, 2: index of the current or in-service line; registered.
- `in_service`, output, 1: high while in SERVICE.
- `pending`, output, 4: latched, not-yet-acknowledged edges.
- `enable`, output, 4: current mask register.

## Operation
- Edge detect:
  - `irq_q` holds the previous `irq_req`.
  - A line has an edge when `irq_req[i] & ~irq_q[i]`; the edge sets `pending[i]`.
  - During reset, `irq_q` loads `irq_req`, so lines held high through reset produce no edge.
- Masked lines still latch into `pending`. They become eligible as soon as they are enabled.
- Priority: eligible = `pending & enable`. The lowest index wins (IRQ0 highest).
- Vector: `VECTOR_BASE + irq_id*VECTOR_STRIDE`, truncated to 16 bits (wraps modulo 2^16).
- State machine has three states: IDLE, REQ, SERVICE.
  - **IDLE:**
    - If eligible ≠ 0, latch the winner into `irq_id` and `irq_vector`, set `interrupt`=1, and go to REQ.
    - Otherwise stay in IDLE.
  - **REQ:**
    - `interrupt`, `irq_id` and `irq_vector` are frozen. A later higher-priority edge or a mask change does not alter or withdraw them.
    - On `irq_ack`=1: clear `pending[irq_id]`, set `interrupt`=0, set `in_service`=1, go to SERVICE.
  - **SERVICE:**
    - `irq_id` keeps the serviced line. New edges still latch into `pending`. No nesting.
    - On `eoi`=1: set `in_service`=0 and go to IDLE.
- Ignored inputs: `irq_ack` outside REQ; `eoi` outside SERVICE.
- Simultaneous set and clear of the same `pending` bit (new edge on the ack cycle): the set wins, and the bit stays 1.
- `mask_we` takes effect on the next edge in any state. Its effect on arbitration is seen from the following cycle.
- Reset values:
  - State IDLE.
  - `interrupt`=0, `irq_vector`=0, `irq_id`=0, `in_service`=0, `pending`=0.
  - `enable`=4'hF.
- Reset asserted mid-REQ or mid-SERVICE aborts immediately to the reset values above; the pending request is discarded.

## Timing
- `irq_req[i]` rises before edge k → `pending[i]`=1 after edge k → `interrupt`=1 after edge k+1. Latency is 2 cycles.
- `irq_ack` sampled at edge m → `interrupt`=0 and `in_service`=1 after edge m.
- `eoi` sampled at edge n → IDLE after edge n. If another line is eligible, `interrupt` is re-raised after edge n+1, so there is a minimum of one low cycle between requests.
- Minimum REQ duration is 1 cycle, when `irq_ack` arrives the cycle after `interrupt` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic request:** reset, then pulse `irq_req`=4'b0100 → `pending`=4'b0100 one cycle later; `interrupt`=1, `irq_id`=2, `irq_vector`=16'h00F8 two cycles after the edge. Assert `irq_ack` → `interrupt`=0, `pending`=0, `in_service`=1. Assert `eoi` → `in_service`=0.
- **Priority and freeze:** raise lines 3 and 1 together → `irq_id`=1, vector 16'h00F4. Raise line 0 while in REQ → `irq_id` stays 1. After ack and eoi, the next request is `irq_id`=0, then `irq_id`=3.
- **Mask:** write `mask_in`=4'b1110, then edge on line 0 → `pending[0]`=1 and `interrupt` stays 0. Write `mask_in`=4'hF → `interrupt`=1 with `irq_id`=0 two cycles after the write.
- **Reset-held level and mid-op reset:**
  - Hold `irq_req[2]`=1 through reset release → no pending bit set.
  - Assert reset during REQ → `interrupt`=0, `pending`=0, `enable`=4'hF on the next edge.
- **Simultaneous events:**
  - A new edge on the serviced line in the same cycle as `irq_ack` → `pending[i]` remains 1, and it is re-requested after eoi.
  - `irq_ack` in IDLE and `eoi` in REQ → no state change.
- **Wrap:** `VECTOR_BASE`=16'hFFFC, `VECTOR_STRIDE`=4, request on line 3 → `irq_vector`=16'h0008.

Source files
------------

// File: rtl/interrupt_control_block.sv
// interrupt_control_block
//   Four-line interrupt controller that drives the processor's single
//   interrupt input. Rising edges on irq_req are latched into pending.
//   pending is ANDed with the enable mask, and the lowest eligible index
//   wins. The request, with its jump vector, is held until irq_ack. The
//   in-service period is then tracked until eoi.
//
// Ports
//   clk         processor clock, rising edge
//   reset       synchronous, active-high
//   irq_req     external request lines (rising edge = request)
//   mask_we     load mask_in into the enable register
//   mask_in     new enable mask (1 = enabled)
//   irq_ack     core took the jump (honoured only while requesting)
//   eoi         handler finished (honoured only while in service)
//   interrupt   registered request to jump control
//   irq_vector  registered handler address
//   irq_id      registered index of the current or in-service line
//   in_service  high while a handler is running
//   pending     latched, not-yet-acknowledged edges
//   enable      current mask register
module interrupt_control_block #(
  parameter logic [15:0] VECTOR_BASE   = 16'h00F0,
  parameter logic [15:0] VECTOR_STRIDE = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_req,
  input  logic        mask_we,
  input  logic [3:0]  mask_in,
  input  logic        irq_ack,
  input  logic        eoi,
  output logic        interrupt,
  output logic [15:0] irq_vector,
  output logic [1:0]  irq_id,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic [3:0]  enable
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_irq_q;
  logic [3:0]  r_pending;
  logic [3:0]  r_enable;
  logic        r_interrupt;
  logic [15:0] r_irq_vector;
  logic [1:0]  r_irq_id;
  logic        r_in_service;

  logic [3:0]  w_edge;
  logic [3:0]  w_eligible;
  logic [3:0]  w_clr;
  logic [3:0]  w_pending_nxt;
  logic [1:0]  w_win;
  logic        w_any;
  logic [15:0] w_win_vector;

  logic        w_interrupt_nxt;
  logic [15:0] w_irq_vector_nxt;
  logic [1:0]  w_irq_id_nxt;
  logic        w_in_service_nxt;

  assign w_edge     = irq_req & ~r_irq_q;
  assign w_eligible = r_pending & r_enable;
  assign w_any      = |w_eligible;

  // Fixed priority: IRQ0 highest.
  always_comb begin
    casez (w_eligible)
      4'b???1: w_win = 2'd0;
      4'b??10: w_win = 2'd1;
      4'b?100: w_win = 2'd2;
      4'b1000: w_win = 2'd3;
      default: w_win = 2'd0;
    endcase
  end

  // The sum is kept at 16 bits, so the vector wraps modulo 2^16.
  assign w_win_vector = VECTOR_BASE + VECTOR_STRIDE * {14'd0, w_win};

  // A new edge on the acknowledged line overrides the clear.
  assign w_clr         = (r_state == ST_REQ && irq_ack) ? (4'b0001 << r_irq_id) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;

  always_comb begin
    w_state_nxt      = r_state;
    w_interrupt_nxt  = r_interrupt;
    w_irq_vector_nxt = r_irq_vector;
    w_irq_id_nxt     = r_irq_id;
    w_in_service_nxt = r_in_service;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt      = ST_REQ;
          w_interrupt_nxt  = 1'b1;
          w_irq_id_nxt     = w_win;
          w_irq_vector_nxt = w_win_vector;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_state_nxt      = ST_SERVICE;
          w_interrupt_nxt  = 1'b0;
          w_in_service_nxt = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          w_state_nxt      = ST_IDLE;
          w_in_service_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // irq_q also tracks irq_req during reset, so lines held high
    // through reset produce no edge.
    r_irq_q <= irq_req;
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_enable     <= '1;
      r_interrupt  <= 1'b0;
      r_irq_vector <= '0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_interrupt  <= w_interrupt_nxt;
      r_irq_vector <= w_irq_vector_nxt;
      r_irq_id     <= w_irq_id_nxt;
      r_in_service <= w_in_service_nxt;
      if (mask_we) r_enable <= mask_in;
    end
  end

  assign interrupt  = r_interrupt;
  assign irq_vector = r_irq_vector;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign enable     = r_enable;

endmodule

// File: tb/tb_interrupt_control_block.sv
module tb_interrupt_control_block;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_req = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_in = '0;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;

  logic        interrupt, in_service;
  logic [15:0] irq_vector;
  logic [1:0]  irq_id;
  logic [3:0]  pending, enable;

  logic        w_interrupt, w_in_service;
  logic [15:0] w_irq_vector;
  logic [1:0]  w_irq_id;
  logic [3:0]  w_pending, w_enable;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  interrupt_control_block u_dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .mask_we(mask_we),
    .mask_in(mask_in), .irq_ack(irq_ack), .eoi(eoi),
    .interrupt(interrupt), .irq_vector(irq_vector), .irq_id(irq_id),
    .in_service(in_service), .pending(pending), .enable(enable)
  );

  interrupt_control_block #(.VECTOR_BASE(16'hFFFC), .VECTOR_STRIDE(16'd4)) u_wrap (
    .clk(clk), .reset(reset), .irq_req(irq_req), .mask_we(mask_we),
    .mask_in(mask_in), .irq_ack(irq_ack), .eoi(eoi),
    .interrupt(w_interrupt), .irq_vector(w_irq_vector), .irq_id(w_irq_id),
    .in_service(w_in_service), .pending(w_pending), .enable(w_enable)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = handler running.
  int         m_phase = 0;
  int         m_id = 0;
  logic [3:0] m_prev = '0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_en = 4'hF;
  int         m_vec0 = 0;
  int         m_vec1 = 0;

  initial forever begin
    logic [3:0] e, el;
    int win;
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_id = 0; m_pend = '0; m_en = 4'hF; m_vec0 = 0; m_vec1 = 0;
    end else begin
      e  = irq_req & ~m_prev;
      el = m_pend & m_en;
      win = -1;
      for (int i = 0; i < 4; i++) if (el[i] && win < 0) win = i;
      case (m_phase)
        0: if (win >= 0) begin
             m_phase = 1;
             m_id = win;
             m_vec0 = (16'h00F0 + win * 4) % 65536;
             m_vec1 = (16'hFFFC + win * 4) % 65536;
           end
        1: if (irq_ack) begin m_pend[m_id] = 1'b0; m_phase = 2; end
        2: if (eoi) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_pend = m_pend | e;
      if (mask_we) m_en = mask_in;
    end
    m_prev = irq_req;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("interrupt",  32'(interrupt),  32'(m_phase == 1));
      chk("in_service", 32'(in_service), 32'(m_phase == 2));
      chk("irq_id",     32'(irq_id),     32'(m_id));
      chk("irq_vector", 32'(irq_vector), 32'(m_vec0));
      chk("pending",    32'(pending),    32'(m_pend));
      chk("enable",     32'(enable),     32'(m_en));
      chk("wrap_vector",    32'(w_irq_vector), 32'(m_vec1));
      chk("wrap_interrupt", 32'(w_interrupt),  32'(m_phase == 1));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step(); step();
    cmp_en = 1'b1;
    chk("rst_interrupt", 32'(interrupt), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_enable", 32'(enable), 32'hF);
    chk("rst_vector", 32'(irq_vector), 0);
    reset = 1'b0;
    step();

    // Basic request on line 2
    irq_req = 4'b0100; step();
    chk("basic_pending", 32'(pending), 32'b0100);
    chk("basic_int_early", 32'(interrupt), 0);
    irq_req = 4'b0000; step();
    chk("basic_int", 32'(interrupt), 1);
    chk("basic_id", 32'(irq_id), 2);
    chk("basic_vec", 32'(irq_vector), 32'h00F8);
    irq_ack = 1'b1; step();
    chk("basic_ack_int", 32'(interrupt), 0);
    chk("basic_ack_pend", 32'(pending), 0);
    chk("basic_ack_svc", 32'(in_service), 1);
    irq_ack = 1'b0; eoi = 1'b1; step();
    chk("basic_eoi_svc", 32'(in_service), 0);
    eoi = 1'b0;

    // Priority and freeze
    irq_req = 4'b1010; step();
    chk("prio_pending", 32'(pending), 32'b1010);
    step();
    chk("prio_id", 32'(irq_id), 1);
    chk("prio_vec", 32'(irq_vector), 32'h00F4);
    irq_req = 4'b1011; step();
    chk("freeze_id", 32'(irq_id), 1);
    chk("freeze_pend", 32'(pending), 32'b1011);
    irq_ack = 1'b1; step();
    chk("prio_ack_pend", 32'(pending), 32'b1001);
    irq_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0; step();
    chk("prio_next_int", 32'(interrupt), 1);
    chk("prio_next_id", 32'(irq_id), 0);
    chk("prio_next_vec", 32'(irq_vector), 32'h00F0);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0; step();
    chk("prio_last_id", 32'(irq_id), 3);
    chk("prio_last_vec", 32'(irq_vector), 32'h00FC);
    chk("wrap_vec_line3", 32'(w_irq_vector), 32'h0008);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; eoi = 1'b1; irq_req = 4'b0000; step();
    eoi = 1'b0;

    // Mask
    mask_we = 1'b1; mask_in = 4'b1110; step();
    chk("mask_enable", 32'(enable), 32'hE);
    mask_we = 1'b0; irq_req = 4'b0001; step();
    chk("mask_pending", 32'(pending), 32'b0001);
    irq_req = 4'b0000; step(); step();
    chk("mask_no_int", 32'(interrupt), 0);
    mask_we = 1'b1; mask_in = 4'hF; step();
    chk("mask_write_int", 32'(interrupt), 0);
    mask_we = 1'b0; step();
    chk("unmask_int", 32'(interrupt), 1);
    chk("unmask_id", 32'(irq_id), 0);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0;

    // Level held through reset
    irq_req = 4'b0100; reset = 1'b1; step(); step();
    reset = 1'b0; step(); step();
    chk("held_pending", 32'(pending), 0);
    chk("held_int", 32'(interrupt), 0);
    irq_req = 4'b0000;

    // Reset in the middle of a request
    irq_req = 4'b0110; step();
    irq_req = 4'b0000; step();
    chk("midreq_int", 32'(interrupt), 1);
    chk("midreq_id", 32'(irq_id), 1);
    mask_we = 1'b1; mask_in = 4'b0111; step();
    chk("midreq_mask_en", 32'(enable), 32'h7);
    chk("midreq_mask_int", 32'(interrupt), 1);
    mask_we = 1'b0; reset = 1'b1; step();
    chk("midrst_int", 32'(interrupt), 0);
    chk("midrst_pend", 32'(pending), 0);
    chk("midrst_en", 32'(enable), 32'hF);
    reset = 1'b0;

    // Edge on the acknowledged line, and ignored ack/eoi
    irq_req = 4'b0001; step();
    irq_req = 4'b0000; step();
    chk("sim_int", 32'(interrupt), 1);
    irq_req = 4'b0001; irq_ack = 1'b1; step();
    chk("sim_pend_kept", 32'(pending), 32'b0001);
    chk("sim_svc", 32'(in_service), 1);
    irq_req = 4'b0000; irq_ack = 1'b0; eoi = 1'b1; step();
    chk("sim_eoi_int", 32'(interrupt), 0);
    eoi = 1'b0; step();
    chk("sim_rereq_int", 32'(interrupt), 1);
    chk("sim_rereq_id", 32'(irq_id), 0);
    eoi = 1'b1; step();
    chk("eoi_in_req_int", 32'(interrupt), 1);
    chk("eoi_in_req_svc", 32'(in_service), 0);
    eoi = 1'b0; irq_ack = 1'b1; step();
    chk("sim_ack2_pend", 32'(pending), 0);
    irq_ack = 1'b0; eoi = 1'b1; step();
    eoi = 1'b0; irq_ack = 1'b1; step();
    chk("ack_in_idle_int", 32'(interrupt), 0);
    chk("ack_in_idle_svc", 32'(in_service), 0);
    irq_ack = 1'b0;

    // Random traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 3) == 0) irq_req = 4'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 2) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom);
      reset   = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
